// File: rtl/ifetch_bridge.sv
// ifetch_bridge: connects a CPU instruction-fetch port to a request/grant/rvalid
// memory bus. It holds a one-entry line buffer, so a repeated fetch of the same
// word returns its data in the same cycle without going to memory. A fetch that
// never completes ends after a cycle budget and returns NOP_INST.
module ifetch_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INST       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rom_addr_i,
    input  logic        rom_ce_i,
    output logic [31:0] rom_data_o,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o,
    output logic [15:0] miss_cnt_o
);

    // state  | meaning
    // S_IDLE | no fetch outstanding; a hit is served from the line buffer
    // S_REQ  | mem_req_o asserted with the captured address, waiting for grant
    // S_WAIT | request accepted, waiting for read data
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        buf_valid_q, buf_valid_d;
    logic [29:0] buf_tag_q, buf_tag_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [15:0] miss_q, miss_d;

    logic        hit;
    logic        miss;
    logic        tmo_expired;

    // Byte-offset bits of the fetch address play no part in a word fetch.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^rom_addr_i[1:0];

    // Hit/miss decode and the CPU-facing outputs, all combinational.
    always_comb begin
        hit         = rom_ce_i && buf_valid_q && (buf_tag_q == rom_addr_i[31:2])
                      && (state_q == S_IDLE);
        miss        = rom_ce_i && !hit;
        tmo_expired = (tmo_q == TMO_LAST);
        rom_data_o  = (!rst && hit) ? buf_data_q : NOP_INST;
        stallreq_o  = !rst && miss;
        mem_req_o   = (state_q == S_REQ);
        mem_addr_o  = addr_q;
        err_o       = err_q;
        miss_cnt_o  = miss_q;
    end

    // Next-state logic for the fetch FSM, line buffer, timeout and counters.
    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        addr_d      = addr_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        miss_d      = miss_q;

        unique case (state_q)
            S_IDLE: begin
                if (miss) begin
                    state_d = S_REQ;
                    addr_d  = {rom_addr_i[31:2], 2'b00};
                    tmo_d   = 16'd0;
                    if (miss_q != 16'hFFFF) begin
                        miss_d = miss_q + 16'd1;
                    end
                end
            end
            S_REQ: begin
                tmo_d = tmo_q + 16'd1;
                if (tmo_expired) begin
                    state_d     = S_IDLE;
                    buf_valid_d = 1'b1;
                    buf_tag_d   = addr_q[31:2];
                    buf_data_d  = NOP_INST;
                    err_d       = 1'b1;
                end else if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                tmo_d = tmo_q + 16'd1;
                // Real data takes priority over a timeout landing on the same cycle.
                if (mem_rvalid_i) begin
                    state_d     = S_IDLE;
                    buf_valid_d = 1'b1;
                    buf_tag_d   = addr_q[31:2];
                    buf_data_d  = mem_rdata_i;
                end else if (tmo_expired) begin
                    state_d     = S_IDLE;
                    buf_valid_d = 1'b1;
                    buf_tag_d   = addr_q[31:2];
                    buf_data_d  = NOP_INST;
                    err_d       = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any fetch in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            addr_q      <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            addr_q      <= addr_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            miss_q      <= miss_d;
        end
    end

endmodule

// File: tb/tb_ifetch_bridge.sv
// Directed bench for ifetch_bridge built with an 8-cycle fetch timeout.
module tb_ifetch_bridge;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rom_addr_i;
    logic        rom_ce_i;
    logic [31:0] rom_data_o;
    logic        stallreq_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;
    logic [15:0] miss_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    ifetch_bridge #(
        .TIMEOUT_CYCLES(8),
        .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rom_addr_i(rom_addr_i),
        .rom_ce_i(rom_ce_i),
        .rom_data_o(rom_data_o),
        .stallreq_o(stallreq_o),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .err_o(err_o),
        .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs and outputs are then handled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs have just changed; let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; rom_ce_i = 1'b1; rom_addr_i = 32'h4;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        settle();
        chk("rst_stall", 32'(stallreq_o), 32'd0);
        chk("rst_data", rom_data_o, NOP);
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_miss", 32'(miss_cnt_o), 32'd0);
        chk("rst_stall2", 32'(stallreq_o), 32'd0);

        // Cold miss at 0x4: three stall cycles, then a hit.
        rst = 1'b0; settle();
        chk("cold_stall_idle", 32'(stallreq_o), 32'd1);
        chk("cold_req_idle", 32'(mem_req_o), 32'd0);
        tick();
        chk("cold_req", 32'(mem_req_o), 32'd1);
        chk("cold_addr", mem_addr_o, 32'h4);
        chk("cold_stall_req", 32'(stallreq_o), 32'd1);
        chk("cold_miss_cnt", 32'(miss_cnt_o), 32'd1);
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3401_1100;
        settle();
        chk("cold_req_wait", 32'(mem_req_o), 32'd0);
        chk("cold_stall_wait", 32'(stallreq_o), 32'd1);
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'hFFFF_FFFF;
        settle();
        chk("cold_stall_done", 32'(stallreq_o), 32'd0);
        chk("cold_data", rom_data_o, 32'h3401_1100);
        chk("cold_miss_done", 32'(miss_cnt_o), 32'd1);

        // Repeated hits for five cycles, including a different byte offset in the same word.
        for (int i = 0; i < 5; i++) begin
            rom_addr_i = (i == 3) ? 32'h7 : 32'h4;
            settle();
            chk("hit_stall", 32'(stallreq_o), 32'd0);
            chk("hit_req", 32'(mem_req_o), 32'd0);
            chk("hit_data", rom_data_o, 32'h3401_1100);
            tick();
        end
        chk("hit_miss_cnt", 32'(miss_cnt_o), 32'd1);

        // Slow grant at 0x102 (word 0x100): request held 5 cycles.
        rom_addr_i = 32'h102; settle();
        chk("slow_stall_idle", 32'(stallreq_o), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("slow_req_hold", 32'(mem_req_o), 32'd1);
            chk("slow_addr_hold", mem_addr_o, 32'h100);
            tick();
        end
        chk("slow_req_5th", 32'(mem_req_o), 32'd1);
        chk("slow_addr_5th", mem_addr_o, 32'h100);
        mem_gnt_i = 1'b1;
        tick();
        // Address moves while the fetch is in WAIT; the captured fetch still fills.
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        rom_addr_i = 32'h104; settle();
        chk("slow_addr_wait", mem_addr_o, 32'h100);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk("moved_addr_misses", 32'(stallreq_o), 32'd1);
        chk("slow_miss_cnt", 32'(miss_cnt_o), 32'd2);
        rom_ce_i = 1'b0; settle();
        chk("ce0_stall", 32'(stallreq_o), 32'd0);
        chk("ce0_data", rom_data_o, NOP);
        rom_ce_i = 1'b1; rom_addr_i = 32'h100; settle();
        chk("slow_fill_hit", rom_data_o, 32'hDEAD_BEEF);
        chk("slow_fill_stall", 32'(stallreq_o), 32'd0);

        // ce=0 at 0x10: no fetch started.
        rom_ce_i = 1'b0; rom_addr_i = 32'h10;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ce0_loop_req", 32'(mem_req_o), 32'd0);
            chk("ce0_loop_stall", 32'(stallreq_o), 32'd0);
            chk("ce0_loop_data", rom_data_o, NOP);
            tick();
        end
        chk("ce0_miss_cnt", 32'(miss_cnt_o), 32'd2);

        // rvalid on the timeout cycle: real data wins, no error.
        rom_ce_i = 1'b1; rom_addr_i = 32'h24; settle();
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_0001; settle();
        chk("edge_stall", 32'(stallreq_o), 32'd1);
        tick();
        mem_rvalid_i = 1'b0; settle();
        chk("edge_data", rom_data_o, 32'hCAFE_0001);
        chk("edge_err", 32'(err_o), 32'd0);
        chk("edge_stall_done", 32'(stallreq_o), 32'd0);
        chk("edge_miss_cnt", 32'(miss_cnt_o), 32'd3);

        // Timeout at 0x20: eight REQ/WAIT cycles, then NOP fill and sticky error.
        rom_addr_i = 32'h20; settle();
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            settle();
            chk("tmo_stall", 32'(stallreq_o), 32'd1);
            chk("tmo_err_pending", 32'(err_o), 32'd0);
            tick();
        end
        chk("tmo_err", 32'(err_o), 32'd1);
        chk("tmo_stall_released", 32'(stallreq_o), 32'd0);
        chk("tmo_data", rom_data_o, NOP);
        chk("tmo_miss_cnt", 32'(miss_cnt_o), 32'd4);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
        tick();
        mem_rvalid_i = 1'b0; settle();
        chk("late_rvalid_data", rom_data_o, NOP);
        chk("late_rvalid_stall", 32'(stallreq_o), 32'd0);
        chk("late_rvalid_req", 32'(mem_req_o), 32'd0);
        chk("err_sticky", 32'(err_o), 32'd1);

        // Reset while in WAIT.
        rom_addr_i = 32'h40; settle();
        tick();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; rst = 1'b1; settle();
        chk("rst_wait_stall", 32'(stallreq_o), 32'd0);
        chk("rst_wait_data", rom_data_o, NOP);
        tick();
        rst = 1'b0; settle();
        chk("post_rst_req", 32'(mem_req_o), 32'd0);
        chk("post_rst_err", 32'(err_o), 32'd0);
        chk("post_rst_miss", 32'(miss_cnt_o), 32'd0);
        chk("post_rst_remiss", 32'(stallreq_o), 32'd1);
        tick();
        chk("post_rst_req2", 32'(mem_req_o), 32'd1);
        chk("post_rst_addr", mem_addr_o, 32'h40);
        chk("post_rst_miss2", 32'(miss_cnt_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_bridge.md
IFETCH_BRIDGE -- requirements
Module: ifetch_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the cycle limit for one outstanding fetch (range 2..65535).
REQ-002 Parameter NOP_INST, default 32'h0000_0000, SHALL be the instruction returned for disabled or timed-out fetches.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 rom_addr_i  input  32  SHALL carry the CPU fetch address (pc).
REQ-006 rom_ce_i  input  1  SHALL be the CPU fetch enable.
REQ-007 rom_data_o  output  32  SHALL carry the instruction returned to the CPU.
REQ-008 stallreq_o  output  1  SHALL request a pipeline stall while a fetch is unresolved.
REQ-009 mem_req_o  output  1  SHALL be the memory read request.
REQ-010 mem_addr_o  output  32  SHALL be the word-aligned memory address.
REQ-011 mem_gnt_i  input  1  SHALL be the memory request accept.
REQ-012 mem_rvalid_i  input  1  SHALL mark valid read data.
REQ-013 mem_rdata_i  input  32  SHALL carry the read data.
REQ-014 err_o  output  1  SHALL be the sticky fetch-timeout flag.
REQ-015 miss_cnt_o  output  16  SHALL be the saturating miss counter.

Function
REQ-016 The block SHALL hold a one-entry line buffer: valid bit, tag = address[31:2], 32-bit data.
REQ-017 Hit SHALL be rom_ce_i=1, buffer valid, tag == rom_addr_i[31:2], state IDLE; on hit rom_data_o = buffer data, stallreq_o=0, same cycle (combinational).
REQ-018 With rom_ce_i=0: rom_data_o=NOP_INST, stallreq_o=0, no request started.
REQ-019 Miss (rom_ce_i=1, not hit) SHALL drive stallreq_o=1 combinationally, and stallreq_o SHALL stay 1 in REQ and WAIT.
REQ-020 FSM states IDLE, REQ, WAIT; IDLE->REQ on miss in IDLE, capturing {rom_addr_i[31:2],2'b00} into the request-address register; miss_cnt_o increments by 1, saturating at 16'hFFFF.
REQ-021 In REQ: mem_req_o=1, mem_addr_o = captured address; REQ->WAIT on mem_gnt_i=1.
REQ-022 Outside REQ: mem_req_o=0, mem_addr_o = captured address.
REQ-023 In WAIT, on mem_rvalid_i=1: buffer <= {valid=1, captured tag, mem_rdata_i}; WAIT->IDLE.
REQ-024 mem_rvalid_i SHALL be ignored in IDLE and REQ.
REQ-025 Minimum miss penalty SHALL be 3 stall cycles (gnt in first REQ cycle, rvalid in first WAIT cycle); hit resolves in the 4th cycle.
REQ-026 If rom_addr_i changes while REQ/WAIT, the captured fetch SHALL complete and fill; the new address then misses in IDLE.
REQ-027 A 16-bit timeout counter SHALL clear on IDLE->REQ and increment each cycle in REQ/WAIT.
REQ-028 When the counter reaches TIMEOUT_CYCLES-1 without completion: err_o <= 1, buffer filled with captured tag and NOP_INST, FSM -> IDLE; a late rvalid is dropped per REQ-024.
REQ-029 If mem_rvalid_i=1 in the timeout cycle, the real data SHALL win and err_o SHALL NOT be set.
REQ-030 err_o SHALL remain 1 until reset.

Reset
REQ-031 On rst=1 at a clock edge: state IDLE, buffer valid=0, captured address 0, timeout counter 0, err_o=0, miss_cnt_o=0.
REQ-032 Reset mid-fetch SHALL abandon the transaction; mem_req_o=0 the cycle after reset is sampled; no fill occurs.
REQ-033 While rst=1, stallreq_o SHALL be 0 and rom_data_o SHALL be NOP_INST.

Verification
REQ-034 Cold miss: addr=0x0000_0004, ce=1, gnt in REQ, rvalid next cycle with 0x3401_1100 -> stallreq_o high exactly 3 cycles, then rom_data_o=0x3401_1100, miss_cnt_o=1.
REQ-035 Repeat hit: same address held 5 cycles after fill -> stallreq_o=0 and mem_req_o=0 throughout; miss_cnt_o unchanged.
REQ-036 Slow grant: gnt delayed 4 cycles -> mem_req_o and mem_addr_o stable for 5 cycles; fill correct.
REQ-037 Timeout: TIMEOUT_CYCLES=8, no rvalid -> err_o=1 after 8 REQ/WAIT cycles, rom_data_o=NOP_INST, stall released; a later rvalid does not change the buffer.
REQ-038 Reset in WAIT -> next cycle mem_req_o=0, err_o=0, miss_cnt_o=0; the same address misses again.
REQ-039 ce=0 with address 0x0000_0010 -> rom_data_o=NOP_INST, stallreq_o=0, no mem_req_o pulse.
